btb_predictor: RTL

- Parametrised branch target buffer for the fetch stage: direct-mapped, with a 2-bit saturating direction counter per entry, a configurable index width and a configurable target width.
- F stage reads a prediction; D/E stages report mispredictions and branch outcomes. The block selects the redirect PC and updates the table.
- A post-reset sweep FSM clears all valid bits so no stale entry can hit.

---
 rtl/btb_predictor_if.sv | 27 ++
 rtl/btb_predictor.sv | 121 ++++++++++++
 2 files changed

// File: rtl/btb_predictor_if.sv
// Fetch/decode/execute signal bundle for the branch target buffer.
interface btb_predictor_if;
  logic [31:0] pcF;
  logic [31:0] prepc;
  logic        hit_predict;
  logic        busy;
  logic [31:0] pcD;
  logic [31:0] nextpcD;
  logic        fail_predictD;
  logic [31:0] pcE;
  logic [31:0] nextpcE;
  logic        fail_predictE;
  logic        br_validE;
  logic        br_takenE;
  logic [31:0] nextpc;
  logic        fail_predict;

  modport master (
    output pcF, pcD, nextpcD, fail_predictD, pcE, nextpcE, fail_predictE, br_validE, br_takenE,
    input  prepc, hit_predict, busy, nextpc, fail_predict
  );

  modport slave (
    input  pcF, pcD, nextpcD, fail_predictD, pcE, nextpcE, fail_predictE, br_validE, br_takenE,
    output prepc, hit_predict, busy, nextpc, fail_predict
  );
endinterface

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit direction counters and a post-reset valid-clearing sweep.
module btb_predictor #(
  parameter int unsigned IDX_BITS = 11,
  parameter int unsigned TGT_BITS = 13,
  parameter logic [31:0] PC_BASE  = 32'h0000_8000,
  parameter logic [1:0]  CNT_INIT = 2'b10
) (
  input logic             CLK,
  input logic             RST,
  btb_predictor_if.slave  bus
);

  localparam int unsigned Depth   = 2 ** IDX_BITS;
  localparam int unsigned TagBits = TGT_BITS - IDX_BITS;

  typedef logic [IDX_BITS-1:0] idx_t;
  typedef logic [TagBits-1:0]  tag_t;
  typedef logic [TGT_BITS-1:0] tgt_t;

  typedef struct packed {
    logic       valid;
    tag_t       tag;
    tgt_t       target;
    logic [1:0] cnt;
  } entry_t;

  typedef enum logic [0:0] {StInit, StReady} state_e;

  entry_t mem_q [Depth];
  state_e state_q, state_d;
  idx_t   ptr_q, ptr_d;

  logic   wr_en;
  idx_t   wr_idx;
  entry_t wr_entry;

  idx_t   f_idx, e_idx;
  tag_t   f_tag, e_tag;
  entry_t f_ent, e_ent;
  logic   f_hit, e_hit, ready;

  assign ready = (state_q == StReady);

  assign f_idx = bus.pcF[IDX_BITS+1:2];
  assign f_tag = bus.pcF[TGT_BITS+1:IDX_BITS+2];
  assign e_idx = bus.pcE[IDX_BITS+1:2];
  assign e_tag = bus.pcE[TGT_BITS+1:IDX_BITS+2];
  assign f_ent = mem_q[f_idx];
  assign e_ent = mem_q[e_idx];
  assign f_hit = f_ent.valid && (f_ent.tag == f_tag);
  assign e_hit = e_ent.valid && (e_ent.tag == e_tag);

  assign bus.hit_predict  = ready & f_hit & f_ent.cnt[1];
  assign bus.prepc        = PC_BASE | {{(30 - TGT_BITS){1'b0}}, f_ent.target, 2'b00};
  assign bus.busy         = ~ready;
  assign bus.nextpc       = bus.fail_predictE ? bus.nextpcE : bus.nextpcD;
  assign bus.fail_predict = bus.fail_predictD | bus.fail_predictE;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StInit;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StInit: begin
        ptr_d = ptr_q + idx_t'(1);
        if (ptr_q == idx_t'(Depth - 1)) state_d = StReady;
      end
      StReady: ;
      default: state_d = StInit;
    endcase
  end

  // Single write port: sweep, then E branch/mispredict, then D (flushed if E writes).
  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = e_idx;
    wr_entry = e_ent;
    if (!ready) begin
      wr_en    = 1'b1;
      wr_idx   = ptr_q;
      wr_entry = '0;
    end else if (bus.br_validE) begin
      if (e_hit) begin
        wr_en = 1'b1;
        if (bus.br_takenE) begin
          wr_entry.cnt    = (e_ent.cnt == 2'b11) ? 2'b11 : e_ent.cnt + 2'd1;
          wr_entry.target = bus.nextpcE[TGT_BITS+1:2];
        end else begin
          wr_entry.cnt = (e_ent.cnt == 2'b00) ? 2'b00 : e_ent.cnt - 2'd1;
        end
      end else if (bus.br_takenE) begin
        wr_en    = 1'b1;
        wr_entry = '{valid: 1'b1, tag: e_tag, target: bus.nextpcE[TGT_BITS+1:2], cnt: CNT_INIT};
      end
    end else if (bus.fail_predictE) begin
      wr_en    = 1'b1;
      wr_entry = '{valid: 1'b1, tag: e_tag, target: bus.nextpcE[TGT_BITS+1:2], cnt: 2'b11};
    end
    if (ready && !wr_en && bus.fail_predictD) begin
      wr_en    = 1'b1;
      wr_idx   = bus.pcD[IDX_BITS+1:2];
      wr_entry = '{valid: 1'b1, tag: bus.pcD[TGT_BITS+1:IDX_BITS+2],
                   target: bus.nextpcD[TGT_BITS+1:2], cnt: 2'b11};
    end
    if (RST) wr_en = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_idx] <= wr_entry;
  end

endmodule
